// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16-bit MSB-first shift-and-add multiplier driving a shared Hack ALU.
// Define ALU_MUL_SKIP_EN to skip the add step for zero multiplier bits.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        zr,
    output logic        ng,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
);
`ifdef ALU_MUL_SKIP_EN
    localparam logic SKIP = 1'b1;
`else
    localparam logic SKIP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, DBL, ADD, DONE} state_t;
    state_t state, state_nx;
    logic [15:0] a_r, b_r, acc;
    logic [3:0] i;
    logic skip_add;
    logic unused_flags;
    assign unused_flags = alu_zr ^ alu_ng;
    assign busy = state != IDLE;
    assign skip_add = SKIP && !b_r[i];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            i       <= '0;
            done    <= 1'b0;
            product <= '0;
            zr      <= 1'b1;
            ng      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == DONE;
            if (state == IDLE && start) begin
                a_r <= a;
                b_r <= b;
                acc <= '0;
                i   <= 4'd15;
            end
            if (state == DBL || state == ADD)
                acc <= alu_out;
            // i moves on after ADD, or after DBL when that bit's ADD is skipped
            if (state == ADD || (state == DBL && skip_add))
                i <= i - 4'd1;
            if (state == DONE) begin
                product <= acc;
                zr      <= acc == 16'd0;
                ng      <= acc[15];
            end
        end
    end
    always_comb begin
        state_nx = state;
        alu_x    = '0;
        alu_y    = '0;
        alu_zx   = 1'b0;
        alu_nx   = 1'b0;
        alu_zy   = 1'b0;
        alu_ny   = 1'b0;
        alu_f    = 1'b0;
        alu_no   = 1'b0;
        case (state)
            IDLE: state_nx = start ? DBL : IDLE;
            DBL: begin
                alu_x    = acc;
                alu_y    = acc;
                alu_f    = 1'b1;
                state_nx = !skip_add ? ADD : (i == 4'd0) ? DONE : DBL;
            end
            ADD: begin
                alu_x    = a_r;
                alu_y    = acc;
                alu_f    = 1'b1;
                alu_zx   = ~b_r[i];
                state_nx = (i == 4'd0) ? DONE : DBL;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle 16-bit multiply sequencer that drives the shared Hack-style ALU through its control pins. It uses MSB-first shift-and-add, issuing only ALU add operations: double the accumulator, then conditionally add the multiplicand. It sits beside the ALU in the CPU datapath, owns the ALU ports while busy, and returns the low 16 bits of the product with zero/negative flags.

## Interface
- Parameters: none (word width fixed at 16 to match the ALU).
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  16  multiplicand, latched on accepted start
- b  input  16  multiplier, latched on accepted start
- busy  output  1  high while an operation is in progress (not IDLE)
- done  output  1  one-cycle pulse, product valid
- product  output  16  low 16 bits of a*b, held until next done
- zr  output  1  product == 0, registered with product
- ng  output  1  product[15], registered with product
- alu_x, alu_y  output  16  ALU operands
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits
- alu_out  input  16  ALU result, combinational from alu_* outputs
- alu_zr, alu_ng  input  1 each  ALU flags (unused; reserved)

## Operation
- Registers: a_r, b_r, acc (16), bit index i (4), state.
- States: IDLE, DBL, ADD, DONE.
- IDLE: all alu_* outputs 0. On start=1: a_r<=a, b_r<=b, acc<=0, i<=15, go DBL.
- DBL: alu_x=acc, alu_y=acc, f=1, other controls 0 (out=acc+acc). acc<=alu_out. Next state is ADD.
- ADD: alu_x=a_r, alu_y=acc, f=1, alu_zx=~b_r[i], other controls 0 (out=acc+a_r or acc+0). acc<=alu_out. If i==0, go DONE, else i<=i-1 and go DBL.
- DONE: alu_* outputs 0. product<=acc, zr<=(acc==0), ng<=acc[15]. Go IDLE.
- Arithmetic is modulo 2^16, so two's-complement signed and unsigned low halves are both correct. Overflow is not reported.
- start is ignored while busy=1, including in the DONE cycle. a/b changes after acceptance have no effect.
- reset in any state forces IDLE. The in-flight operation is abandoned, and no done is generated for it.

## Timing
- Reset values: busy=0, done=0, product=0x0000, zr=1, ng=0, all alu_* = 0.
- start accepted at edge T. ALU cycles occupy T+1..T+N. DONE state is cycle T+N+1.
- done, product, zr and ng update at the end of the DONE cycle, so they are visible in cycle T+N+2. done is high for exactly that one cycle. busy is high in cycles T+1..T+N+1.
- N=32 (fixed) by default. See Configuration for the alternative.
- A new start can be accepted in the same cycle done is high (state is IDLE).
- The ALU path is purely combinational. alu_out is sampled in the same cycle the alu_* outputs are driven.

## Configuration
- ALU_MUL_SKIP_EN undefined:
  - ADD is always issued, adding 0 when b_r[i]=0.
  - Latency is constant: N=32.
- ALU_MUL_SKIP_EN defined:
  - In DBL, if b_r[i]==0, ADD is skipped. If i==0 the next state is DONE, else i<=i-1 and the next state is DBL.
  - N = 16 + popcount(b).
  - The product is identical in both builds.

## Test plan
- a=3, b=5, start at T -> done high at T+34, product=0x000F, zr=0, ng=0. With SKIP_EN: done at T+20.
- a=0xFFFF, b=0xFFFF -> product=0x0001 (wrap), ng=0, zr=0. a=0xFFFD (-3), b=7 -> product=0xFFEB, ng=1.
- a=0x1234, b=0 -> product=0x0000, zr=1. With SKIP_EN: done at T+18.
- start pulsed with new a/b at T+5 and in the DONE cycle of an operation -> ignored. The first result is unchanged, and no second done occurs.
- reset asserted at T+10 mid-operation -> busy=0, done=0, product=0, zr=1, and alu_* = 0 immediately. The next start then completes normally with the correct result.
- Back-to-back: start held high continuously -> consecutive operations accepted on each done cycle. Each result is correct, and done pulses are spaced N+2 cycles apart.
